adc_input_cond: RTL and testbench
=================================

# adc_input_cond

ADC input conditioning stage in the `adc_clk` domain, directly upstream of the receiver/waterfall top level. It converts the raw offset-binary ADC word to two's complement and optionally removes DC offset with a leaky integrator, saturating the result. It merges the ADC overflow pin with saturation events and tracks windowed peak magnitude for AGC/level telemetry. Its `adc_data`/`adc_ovfl` outputs feed the receiver's `adc_data`/`adc_ovfl` inputs unchanged.

## Interface

- `ADC_BITS`, 14, ADC word width.
- `DC_SHIFT`, 16, integrator time-constant shift, valid range 8..20.
- `PEAK_WIN_LOG2`, 16, peak window is 2^PEAK_WIN_LOG2 samples.

- `adc_clk`  in  1  sample clock; one sample per cycle.
- `reset_n`  in  1  asynchronous, active-low reset.
- `adc_raw`  in  ADC_BITS  offset-binary ADC word.
- `adc_ovfl_raw`  in  1  ADC overrange pin, sample-aligned with `adc_raw`.
- `dc_en`  in  1  level; 1 = DC removal active. Already quasi-static in `adc_clk` domain.
- `adc_data`  out  ADC_BITS  signed conditioned sample.
- `adc_ovfl`  out  1  overrange or saturation, aligned with `adc_data`.
- `dc_est`  out  ADC_BITS  signed current DC estimate.
- `peak_mag`  out  ADC_BITS-1  peak magnitude of last completed window.
- `peak_valid`  out  1  one-cycle pulse when `peak_mag` updates.

## Operation

- Reset values: `adc_data`=0, `adc_ovfl`=0, `dc_est`=0, `peak_mag`=0, `peak_valid`=0. Integrator, running max and window counter are 0.
- Stage 1 registers `s1` = `adc_raw` with MSB inverted, interpreted as signed, and `o1` = `adc_ovfl_raw`.
- The integrator `acc` is signed, ADC_BITS+DC_SHIFT bits.
  - `dc_est` = `acc` >>> DC_SHIFT (arithmetic), ADC_BITS bits.
- Stage 2:
  - `diff` = `s1` − `dc_est`, computed at ADC_BITS+1 bits.
  - Saturate `diff` to [−2^(ADC_BITS−1), 2^(ADC_BITS−1)−1].
  - Register the result into `adc_data`.
  - `adc_ovfl` <= `o1` | (saturation occurred).
- When `dc_en`=1: `acc` <= `acc` + sign-extended unsaturated `diff` every cycle.
- When `dc_en`=0: `acc` <= 0. Therefore `dc_est`=0, `diff`=`s1`, and no saturation can occur.
- Deasserting `dc_en` clears the estimate on the next edge. Reasserting it restarts convergence from 0.
- Peak tracker, per `adc_data` sample (one per cycle after reset):
  - `mag` = |`adc_data`|, with −2^(ADC_BITS−1) mapped to 2^(ADC_BITS−1)−1. ADC_BITS−1 bits, no truncation wrap.
  - `runmax` <= max(`runmax`, `mag`).
  - The window counter increments modulo 2^PEAK_WIN_LOG2.
- At terminal count (counter all-ones):
  - `peak_mag` <= max(`runmax`, `mag`) so the current sample is included.
  - `peak_valid` <= 1.
  - `runmax` <= 0 and the counter wraps to 0.
- The window counter starts after reset. The first `adc_data` sample counted is the reset-value 0 at cycle 0; this is harmless.

## Timing

- Latency `adc_raw` → `adc_data`/`adc_ovfl`: 2 `adc_clk` edges.
- `dc_est` reflects `acc` after the previous edge. Its update affects `adc_data` one cycle later.
- `peak_valid` is high exactly 1 cycle every 2^PEAK_WIN_LOG2 cycles. The first pulse comes 2^PEAK_WIN_LOG2 cycles after reset release.
- `peak_mag` holds between pulses.
- Async reset mid-window: all state clears immediately and the window restarts. No partial `peak_valid` is produced.
- DC convergence: the time constant is ≈2^DC_SHIFT samples. Steady-state residual on a constant input is within ±1 LSB.

## Test plan

- Conversion, `dc_en`=0: raw 0x2000, 0x0000, 0x3FFF, 0x1FFF → `adc_data` 0, −8192, 8191, −1 exactly 2 cycles later; `adc_ovfl`=0.
- Overflow passthrough: pulse `adc_ovfl_raw` for 1 cycle at N → `adc_ovfl` high only at cycle N+2, with no stretch.
- DC removal, DC_SHIFT=8, `dc_en`=1, constant raw 0x2000+500 → `dc_est` rises monotonically to 500±1 and `adc_data` decays to within ±1 of 0 by 4096 cycles.
- Saturation, `dc_en`=1, settled with `dc_est`=−100:
  - Raw 0x3FFF → `adc_data`=8191, `adc_ovfl`=1.
  - Then raw 0x2000 → `adc_data`=100, `adc_ovfl`=0.
- Peak, PEAK_WIN_LOG2=4, `dc_en`=0:
  - Window containing raw 0x0000 (−8192) → `peak_mag`=8191, `peak_valid` pulses every 16 cycles.
  - Next window with max |x|=37 → `peak_mag`=37.
  - The last sample of a window being the largest is included.
- Reset mid-operation: assert `reset_n`=0 at window cycle 7 with `acc`≠0 → all outputs 0 asynchronously. After release, the next `peak_valid` arrives 16 cycles later and `dc_est` restarts from 0.

Source files
------------

// File: rtl/adc_input_cond.sv
// ADC input conditioning: offset-binary to two's complement, optional leaky-integrator DC
// removal with saturation, overrange merge, and windowed peak-magnitude telemetry.
module adc_input_cond #(
  parameter int ADC_BITS      = 14,
  parameter int DC_SHIFT      = 16,
  parameter int PEAK_WIN_LOG2 = 16
) (
  input  logic                       adc_clk,
  input  logic                       reset_n,
  input  logic [ADC_BITS-1:0]        adc_raw,
  input  logic                       adc_ovfl_raw,
  input  logic                       dc_en,
  output logic signed [ADC_BITS-1:0] adc_data,
  output logic                       adc_ovfl,
  output logic signed [ADC_BITS-1:0] dc_est,
  output logic [ADC_BITS-2:0]        peak_mag,
  output logic                       peak_valid
);

  localparam int ACC_W = ADC_BITS + DC_SHIFT;

  logic signed [ADC_BITS-1:0] r_s1;
  logic                       r_o1;
  logic signed [ACC_W-1:0]    r_acc;
  logic signed [ADC_BITS-1:0] r_data;
  logic                       r_ovfl;
  logic [ADC_BITS-2:0]        r_runmax;
  logic [PEAK_WIN_LOG2-1:0]   r_win_cnt;
  logic [ADC_BITS-2:0]        r_peak_mag;
  logic                       r_peak_valid;

  logic signed [ADC_BITS-1:0] w_dc_est;
  logic signed [ADC_BITS:0]   w_diff;
  logic                       w_sat;
  logic signed [ADC_BITS-1:0] w_diff_sat;
  logic signed [ACC_W-1:0]    w_diff_ext;
  logic [ADC_BITS-2:0]        w_mag;
  logic [ADC_BITS-2:0]        w_peak_next;
  logic                       w_win_last;

  // An arithmetic shift by DC_SHIFT truncated to ADC_BITS is exactly the accumulator's top slice.
  assign w_dc_est = r_acc[ACC_W-1 -: ADC_BITS];

  assign w_diff     = {r_s1[ADC_BITS-1], r_s1} - {w_dc_est[ADC_BITS-1], w_dc_est};
  // The widened difference is out of range exactly when its two top bits disagree.
  assign w_sat      = w_diff[ADC_BITS] ^ w_diff[ADC_BITS-1];
  assign w_diff_sat = w_sat ? {w_diff[ADC_BITS], {(ADC_BITS-1){~w_diff[ADC_BITS]}}}
                            : w_diff[ADC_BITS-1:0];
  // The integrator follows the unsaturated difference so convergence is not slowed by clipping.
  assign w_diff_ext = {{(DC_SHIFT-1){w_diff[ADC_BITS]}}, w_diff};

  // NOTE: every signal driven in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    w_mag = r_data[ADC_BITS-2:0];
    if (r_data[ADC_BITS-1]) begin
      if (r_data[ADC_BITS-2:0] == '0) begin
        w_mag = '1;
      end else begin
        w_mag = ~r_data[ADC_BITS-2:0] + (ADC_BITS-1)'(1);
      end
    end
  end

  assign w_peak_next = (w_mag > r_runmax) ? w_mag : r_runmax;
  assign w_win_last  = &r_win_cnt;

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge adc_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1         <= '0;
      r_o1         <= 1'b0;
      r_acc        <= '0;
      r_data       <= '0;
      r_ovfl       <= 1'b0;
      r_runmax     <= '0;
      r_win_cnt    <= '0;
      r_peak_mag   <= '0;
      r_peak_valid <= 1'b0;
    end else begin
      r_s1   <= {~adc_raw[ADC_BITS-1], adc_raw[ADC_BITS-2:0]};
      r_o1   <= adc_ovfl_raw;
      r_data <= w_diff_sat;
      r_ovfl <= r_o1 | w_sat;
      r_acc  <= dc_en ? (r_acc + w_diff_ext) : '0;

      r_win_cnt    <= r_win_cnt + PEAK_WIN_LOG2'(1);
      r_peak_valid <= w_win_last;
      if (w_win_last) begin
        // The terminal sample is folded into the published peak before the window restarts.
        r_peak_mag <= w_peak_next;
        r_runmax   <= '0;
      end else begin
        r_runmax   <= w_peak_next;
      end
    end
  end

  assign adc_data   = r_data;
  assign adc_ovfl   = r_ovfl;
  assign dc_est     = w_dc_est;
  assign peak_mag   = r_peak_mag;
  assign peak_valid = r_peak_valid;

endmodule

// File: tb/tb_adc_input_cond.sv
// Scoreboard bench for adc_input_cond: stimulus queues expected samples and peaks, and a
// separate monitor compares them as the DUT presents each sample and each peak pulse.
module tb_adc_input_cond;

  localparam int ADC_BITS      = 14;
  localparam int DC_SHIFT      = 8;
  localparam int PEAK_WIN_LOG2 = 4;
  localparam int WIN           = 1 << PEAK_WIN_LOG2;

  logic                       adc_clk;
  logic                       reset_n;
  logic [ADC_BITS-1:0]        adc_raw;
  logic                       adc_ovfl_raw;
  logic                       dc_en;
  logic signed [ADC_BITS-1:0] adc_data;
  logic                       adc_ovfl;
  logic signed [ADC_BITS-1:0] dc_est;
  logic [ADC_BITS-2:0]        peak_mag;
  logic                       peak_valid;

  typedef struct { int unsigned due; int data; bit ovfl; } samp_exp_t;
  typedef struct { int unsigned win; int mag; } peak_exp_t;

  samp_exp_t   sb_q[$];
  peak_exp_t   pk_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned cyc;

  // Signed sample values per peak window; offset-binary raw words are derived from them.
  int pk_vec [3][16] = '{
    '{10, -20, 0, 5, 0, -8192, 300, 0, 0, 7, 0, 0, -1, 0, 0, 2},
    '{1, -37, 5, 0, 0, 36, 0, -2, 0, 0, 0, 0, 0, 0, 0, 3},
    '{4, 0, 0, -9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 11, -600}
  };

  adc_input_cond #(
    .ADC_BITS      (ADC_BITS),
    .DC_SHIFT      (DC_SHIFT),
    .PEAK_WIN_LOG2 (PEAK_WIN_LOG2)
  ) dut (
    .adc_clk      (adc_clk),
    .reset_n      (reset_n),
    .adc_raw      (adc_raw),
    .adc_ovfl_raw (adc_ovfl_raw),
    .dc_en        (dc_en),
    .adc_data     (adc_data),
    .adc_ovfl     (adc_ovfl),
    .dc_est       (dc_est),
    .peak_mag     (peak_mag),
    .peak_valid   (peak_valid)
  );

  initial begin
    adc_clk = 1'b0;
    forever #5 adc_clk = ~adc_clk;
  end

  // Edges since the last reset release.
  always @(posedge adc_clk or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0d, expected %0d", name, cyc, act, req);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0d, expected %0d..%0d", name, cyc, act, lo, hi);
    end
  endtask

  // Called at a negedge; applies one sample and returns at the next negedge.
  task automatic drive(input logic [ADC_BITS-1:0] raw, input logic ovf);
    adc_raw      = raw;
    adc_ovfl_raw = ovf;
    @(negedge adc_clk);
  endtask

  task automatic drive_chk(input logic [ADC_BITS-1:0] raw, input logic ovf,
                           input int exp_d, input bit exp_o);
    sb_q.push_back('{cyc + 2, exp_d, exp_o});
    drive(raw, ovf);
  endtask

  // Monitor: sample outputs on the falling edge, away from the active edge.
  initial begin
    samp_exp_t e;
    bit        exp_pv;
    forever begin
      @(negedge adc_clk);
      while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
        e = sb_q.pop_front();
        if (e.due != cyc) begin
          check("sample_timing", int'(cyc), int'(e.due));
        end else begin
          check("adc_data", int'(adc_data), e.data);
          check("adc_ovfl", int'(adc_ovfl), int'(e.ovfl));
        end
      end
      exp_pv = reset_n && (cyc != 0) && (cyc % WIN == 0);
      if (peak_valid || exp_pv) begin
        check("peak_valid", int'(peak_valid), int'(exp_pv));
        if (peak_valid && exp_pv) begin
          while (pk_q.size() > 0 && pk_q[0].win < cyc / WIN) void'(pk_q.pop_front());
          if (pk_q.size() > 0 && pk_q[0].win == cyc / WIN) begin
            check("peak_mag", int'(peak_mag), pk_q[0].mag);
            void'(pk_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    int                  mono;
    int                  prev;
    int                  j0;
    int unsigned         jp;
    logic [ADC_BITS-1:0] raw;

    reset_n      = 1'b0;
    dc_en        = 1'b0;
    adc_raw      = 14'h2000;
    adc_ovfl_raw = 1'b0;
    repeat (3) @(negedge adc_clk);
    check("rst_adc_data",   int'(adc_data),   0);
    check("rst_adc_ovfl",   int'(adc_ovfl),   0);
    check("rst_dc_est",     int'(dc_est),     0);
    check("rst_peak_mag",   int'(peak_mag),   0);
    check("rst_peak_valid", int'(peak_valid), 0);
    reset_n = 1'b1;

    // Plain conversion with DC removal off.
    drive_chk(14'h2000, 1'b0,     0, 1'b0);
    drive_chk(14'h0000, 1'b0, -8192, 1'b0);
    drive_chk(14'h3FFF, 1'b0,  8191, 1'b0);
    drive_chk(14'h1FFF, 1'b0,    -1, 1'b0);

    // Single-cycle overrange pulse must appear once, two edges later, unstretched.
    drive_chk(14'h2000, 1'b0, 0, 1'b0);
    drive_chk(14'h2000, 1'b1, 0, 1'b1);
    drive_chk(14'h2000, 1'b0, 0, 1'b0);
    drive_chk(14'h2000, 1'b0, 0, 1'b0);

    // Align so the next raw sample lands first in a fresh peak window.
    while (cyc % WIN != WIN - 2) drive(14'h2000, 1'b0);
    j0 = (int'(cyc) + 18) / WIN;
    pk_q.push_back('{j0,     8191});
    pk_q.push_back('{j0 + 1, 37});
    pk_q.push_back('{j0 + 2, 600});
    for (int w = 0; w < 3; w++) begin
      for (int i = 0; i < WIN; i++) begin
        raw = ADC_BITS'(pk_vec[w][i]) ^ 14'h2000;
        drive_chk(raw, 1'b0, pk_vec[w][i], 1'b0);
      end
    end

    // DC removal toward +500; stage 1 is primed first so the estimate only rises.
    drive(14'h21F4, 1'b0);
    drive(14'h21F4, 1'b0);
    dc_en = 1'b1;
    mono  = 1;
    prev  = 0;
    for (int i = 0; i < 4096; i++) begin
      drive(14'h21F4, 1'b0);
      if (int'(dc_est) < prev) mono = 0;
      prev = int'(dc_est);
    end
    check("dc_monotonic", mono, 1);
    check_range("dc_est_500", int'(dc_est), 499, 501);
    check_range("dc_residual", int'(adc_data), -1, 1);

    // Settle at a -100 offset, then a full-scale code must clip and flag.
    repeat (4096) drive(14'h1F9C, 1'b0);
    check("dc_est_m100", int'(dc_est), -100);
    drive_chk(14'h3FFF, 1'b0, 8191, 1'b1);
    repeat (4096) drive(14'h1F9C, 1'b0);
    check("dc_est_resettled", int'(dc_est), -100);
    jp = (cyc + 18) / WIN;
    pk_q.push_back('{jp, 100});
    drive_chk(14'h2000, 1'b0, 100, 1'b0);

    // Reset mid-window with a non-zero integrator.
    while (!(cyc > jp * WIN && cyc % WIN == 7)) drive(14'h1F9C, 1'b0);
    check("peak_mag_hold", int'(peak_mag), 100);
    check_range("dc_est_pre_reset", int'(dc_est), -100, -99);
    check("sb_empty_pre_reset", sb_q.size() + pk_q.size(), 0);
    #1 reset_n = 1'b0;
    #1;
    check("arst_adc_data",   int'(adc_data),   0);
    check("arst_adc_ovfl",   int'(adc_ovfl),   0);
    check("arst_dc_est",     int'(dc_est),     0);
    check("arst_peak_mag",   int'(peak_mag),   0);
    check("arst_peak_valid", int'(peak_valid), 0);
    repeat (2) @(negedge adc_clk);
    reset_n = 1'b1;

    // Integrator restarts from zero: -100 enters with no correction, then estimate is -1.
    pk_q.push_back('{1, 100});
    drive_chk(14'h1F9C, 1'b0, -100, 1'b0);
    check("dc_restart_0", int'(dc_est), 0);
    drive(14'h1F9C, 1'b0);
    check("dc_restart_1", int'(dc_est), -1);
    while (cyc < WIN + 4) drive(14'h1F9C, 1'b0);
    check("sb_drained", sb_q.size() + pk_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
